// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong playfield constants and paddle direction encoding
package pong_pkg;

  localparam int Y_MIN       = 5;
  localparam int Y_MAX       = 476;
  localparam int PADDLE_HALF = 45;
  // Paddle centre limits keep the full paddle span inside the playfield.
  localparam int POS_MIN     = Y_MIN + PADDLE_HALF;
  localparam int POS_MAX     = Y_MAX - PADDLE_HALF - 1;
  localparam int POS_RESET   = 245;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    UP   = 3'b010,
    DOWN = 3'b100
  } dir_t;

endpackage

// File: rtl/paddle_axis.sv
// rtl/paddle_axis.sv - one paddle: button sync/debounce, direction FSM, acceleration, clamped position
module paddle_axis
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_SLOW       = 4,
  parameter int STEP_FAST       = 8,
  parameter int ACCEL_TICKS     = 8
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       raw_up,
  input  logic       raw_down,
  input  logic       use_ai,
  input  logic       ai_up,
  input  logic       ai_down,
  output logic [9:0] position,
  output logic       moving
);

  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] ACCEL_MAX = 4'(ACCEL_TICKS);
  localparam logic signed [10:0] POS_MIN_S = 11'(POS_MIN);
  localparam logic signed [10:0] POS_MAX_S = 11'(POS_MAX);

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0] sync1, sync2, deb;
  logic [3:0] deb_cnt [2];

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {raw_down, raw_up};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      deb        <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 4'd1;
        end
      end
    end
  end

  logic cmd_up, cmd_down;
  assign cmd_up   = use_ai ? ai_up   : deb[0];
  assign cmd_down = use_ai ? ai_down : deb[1];

  dir_t state, next_state;

  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    if (cmd_up && !cmd_down)      next_state = UP;
    else if (cmd_down && !cmd_up) next_state = DOWN;
  end

  always_comb begin
    moving = (state != IDLE);
  end

  // Counts ticks spent in the current non-idle direction.
  logic [3:0] accel_cnt;

  always_ff @(posedge sys_clk) begin
    if (reset || next_state == IDLE || next_state != state) accel_cnt <= '0;
    else if (accel_cnt < ACCEL_MAX)                         accel_cnt <= accel_cnt + 4'd1;
  end

  logic signed [10:0] step, pos_ext, pos_sum;
  logic [9:0] pos_next;

  always_comb begin
    step    = (accel_cnt < ACCEL_MAX) ? 11'(STEP_SLOW) : 11'(STEP_FAST);
    pos_ext = signed'({1'b0, position});
    case (state)
      UP:      pos_sum = pos_ext - step;
      DOWN:    pos_sum = pos_ext + step;
      default: pos_sum = pos_ext;
    endcase
    if (pos_sum < POS_MIN_S)      pos_next = 10'(POS_MIN);
    else if (pos_sum > POS_MAX_S) pos_next = 10'(POS_MAX);
    else                          pos_next = pos_sum[9:0];
  end

  always_ff @(posedge sys_clk) begin
    if (reset) position <= 10'(POS_RESET);
    else       position <= pos_next;
  end

endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - both paddles from raw buttons; PADDLE_AI_EN lets ball_y drive player 2
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_SLOW       = 4,
  parameter int STEP_FAST       = 8,
  parameter int ACCEL_TICKS     = 8,
  parameter int AI_DEADBAND     = 10
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic [9:0] ball_y,
  output logic [9:0] p1_position,
  output logic [9:0] p2_position,
  output logic       p1_moving,
  output logic       p2_moving
);

  logic p2_use_ai, p2_ai_up, p2_ai_down;

`ifdef PADDLE_AI_EN
  localparam logic signed [10:0] DEADBAND = 11'(AI_DEADBAND);
  logic signed [10:0] ball_s, p2_s;
  assign ball_s     = signed'({1'b0, ball_y});
  assign p2_s       = signed'({1'b0, p2_position});
  assign p2_use_ai  = 1'b1;
  assign p2_ai_up   = ball_s < (p2_s - DEADBAND);
  assign p2_ai_down = ball_s > (p2_s + DEADBAND);
`else
  logic unused_ai;
  assign unused_ai  = ^{ball_y, 10'(AI_DEADBAND)};
  assign p2_use_ai  = 1'b0;
  assign p2_ai_up   = 1'b0;
  assign p2_ai_down = 1'b0;
`endif

  paddle_axis #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STEP_SLOW      (STEP_SLOW),
    .STEP_FAST      (STEP_FAST),
    .ACCEL_TICKS    (ACCEL_TICKS)
  ) u_p1 (
    .sys_clk (sys_clk),
    .reset   (reset),
    .raw_up  (p1_up),
    .raw_down(p1_down),
    .use_ai  (1'b0),
    .ai_up   (1'b0),
    .ai_down (1'b0),
    .position(p1_position),
    .moving  (p1_moving)
  );

  paddle_axis #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STEP_SLOW      (STEP_SLOW),
    .STEP_FAST      (STEP_FAST),
    .ACCEL_TICKS    (ACCEL_TICKS)
  ) u_p2 (
    .sys_clk (sys_clk),
    .reset   (reset),
    .raw_up  (p2_up),
    .raw_down(p2_down),
    .use_ai  (p2_use_ai),
    .ai_up   (p2_ai_up),
    .ai_down (p2_ai_down),
    .position(p2_position),
    .moving  (p2_moving)
  );

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - randomized bench for paddle_ctrl against a behavioural paddle model
module tb_paddle_ctrl;

  localparam int D  = 4;
  localparam int SS = 4;
  localparam int SF = 8;
  localparam int AT = 8;
  localparam int DB = 10;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [9:0] ball_y = 10'd245;
  logic [9:0] p1_position, p2_position;
  logic       p1_moving, p2_moving;

  int n_checks = 0;
  int n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  paddle_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .STEP_SLOW      (SS),
    .STEP_FAST      (SF),
    .ACCEL_TICKS    (AT),
    .AI_DEADBAND    (DB)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .p1_up      (p1_up),
    .p1_down    (p1_down),
    .p2_up      (p2_up),
    .p2_down    (p2_down),
    .ball_y     (ball_y),
    .p1_position(p1_position),
    .p2_position(p2_position),
    .p1_moving  (p1_moving),
    .p2_moving  (p2_moving)
  );

  // Model: raw button history per edge, debounced levels, direction (0 idle, 1 up, 2 down),
  // edge at which the current direction began, and the paddle position.
  int n = 0;
  int rst_edge = 0;
  bit rh [2][2][32];
  bit m_deb [2][2];
  int m_flip [2][2];
  int m_dir [2];
  int m_since [2];
  int m_pos [2];

  // Synchronized level seen by the debouncer at edge e: the raw level two edges earlier.
  function automatic bit sync_at(int p, int b, int e);
    if (e - 2 <= rst_edge) return 1'b0;
    return rh[p][b][(e - 2) % 32];
  endfunction

  always @(posedge sys_clk) begin
    int old_pos, held, step, nd;
    bit all_diff;
    n = n + 1;
    rh[0][0][n % 32] = p1_up;
    rh[0][1][n % 32] = p1_down;
    rh[1][0][n % 32] = p2_up;
    rh[1][1][n % 32] = p2_down;
    if (reset) begin
      rst_edge = n;
      for (int p = 0; p < 2; p++) begin
        m_pos[p] = 245;
        m_dir[p] = 0;
        m_since[p] = n;
        for (int b = 0; b < 2; b++) begin
          m_deb[p][b] = 1'b0;
          m_flip[p][b] = n;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        old_pos = m_pos[p];
        held = n - 1 - m_since[p];
        step = (held < AT) ? SS : SF;
        if (m_dir[p] == 1) m_pos[p] = m_pos[p] - step;
        if (m_dir[p] == 2) m_pos[p] = m_pos[p] + step;
        if (m_pos[p] < 50) m_pos[p] = 50;
        if (m_pos[p] > 430) m_pos[p] = 430;
        nd = 0;
        if (m_deb[p][0] && !m_deb[p][1]) nd = 1;
        if (m_deb[p][1] && !m_deb[p][0]) nd = 2;
`ifdef PADDLE_AI_EN
        if (p == 1) begin
          nd = 0;
          if (int'(ball_y) < old_pos - DB) nd = 1;
          if (int'(ball_y) > old_pos + DB) nd = 2;
        end
`endif
        if (nd != m_dir[p]) begin
          m_dir[p] = nd;
          m_since[p] = n;
        end
        // A debounced level flips once the last D samples since its previous flip all disagree.
        for (int b = 0; b < 2; b++) begin
          if (n - m_flip[p][b] >= D) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++)
              if (sync_at(p, b, n - k) == m_deb[p][b]) all_diff = 1'b0;
            if (all_diff) begin
              m_deb[p][b] = ~m_deb[p][b];
              m_flip[p][b] = n;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (n > 0) begin
      chk("p1_position", int'(p1_position), m_pos[0]);
      chk("p2_position", int'(p2_position), m_pos[1]);
      chk("p1_moving", int'(p1_moving), int'(m_dir[0] != 0));
      chk("p2_moving", int'(p2_moving), int'(m_dir[1] != 0));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset held with every button pressed.
    p1_up = 1'b1; p1_down = 1'b1; p2_up = 1'b1; p2_down = 1'b1;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    chk("lit_rst_p1_pos", int'(p1_position), 245);
    chk("lit_rst_p2_pos", int'(p2_position), 245);
    chk("lit_rst_p1_mov", int'(p1_moving), 0);
    chk("lit_rst_p2_mov", int'(p2_moving), 0);

    // Slow then fast: first move at edge 8, 317 after edge 20.
    do_reset();
    p1_down = 1'b1;
    repeat (7) @(negedge sys_clk);
    chk("lit_accel_e7", int'(p1_position), 245);
    chk("lit_accel_mov_e7", int'(p1_moving), 1);
    @(negedge sys_clk);
    chk("lit_accel_e8", int'(p1_position), 249);
    repeat (12) @(negedge sys_clk);
    chk("lit_accel_e20", int'(p1_position), 317);

    // Clamp at the top limit.
    do_reset();
    p1_up = 1'b1;
    repeat (100) @(negedge sys_clk);
    chk("lit_clamp_pos", int'(p1_position), 50);
    chk("lit_clamp_mov", int'(p1_moving), 1);

    // Short glitch on p2_up is rejected.
    do_reset();
    p2_up = 1'b1;
    repeat (3) @(negedge sys_clk);
    p2_up = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("lit_glitch_pos", int'(p2_position), 245);
    chk("lit_glitch_mov", int'(p2_moving), 0);

    // Both buttons held means idle.
    do_reset();
    p1_up = 1'b1; p1_down = 1'b1;
    repeat (30) @(negedge sys_clk);
    chk("lit_both_pos", int'(p1_position), 245);
    chk("lit_both_mov", int'(p1_moving), 0);

`ifdef PADDLE_AI_EN
    do_reset();
    ball_y = 10'd400;
    for (int i = 0; i < 150; i++) begin
      @(negedge sys_clk);
      p2_up = 1'($urandom_range(0, 1));
      p2_down = 1'($urandom_range(0, 1));
    end
    chk("lit_ai_near", int'(p2_position >= 10'd390 && p2_position <= 10'd410), 1);
    ball_y = 10'd245;
`endif

    // Randomized play with occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 9) == 0) p1_up = ~p1_up;
      if ($urandom_range(0, 9) == 0) p1_down = ~p1_down;
      if ($urandom_range(0, 9) == 0) p2_up = ~p2_up;
      if ($urandom_range(0, 9) == 0) p2_down = ~p2_down;
      if ($urandom_range(0, 2) == 0) begin
        // Fast chatter exercises glitch rejection.
        p1_up = ~p1_up;
      end
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) ball_y = 10'($urandom_range(0, 479));
    end
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
